// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 8 lines x 16 bytes over a 1 KiB space.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module icache_ctrl (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  localparam int unsigned LINES  = 8;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BADR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  state_e              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic                mem_read_q;
  logic [BADR_W-1:0]   mem_addr_q;

  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    pc_idx;
  logic [1:0]          pc_word;
  logic                hit;
  logic                fill_c;
  logic                unused_pc;

  assign pc_tag    = PC[9:7];
  assign pc_idx    = PC[6:4];
  assign pc_word   = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  // Tag/data are unreset, so every lookup is qualified by the valid bit first.
  assign hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign fill_c = (state_q == FETCH) && !MEM_BUSYWAIT;

  assign BUSYWAIT    = (state_q != IDLE) || !hit;
  assign INSTRUCTION = BUSYWAIT ? '0 : data_q[pc_idx][{pc_word, 5'd0} +: WORD_W];
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_addr_q;

  // Controller FSM; the fill address is captured on the miss so PC may wander during FETCH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_q    <= FETCH;
            mem_read_q <= 1'b1;
            mem_addr_q <= {pc_tag, pc_idx};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_q                       <= UPDATE;
            mem_read_q                    <= 1'b0;
            valid_q[mem_addr_q[IDX_W-1:0]] <= 1'b1;
          end
        end
        UPDATE: state_q <= IDLE;
        default: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Line payload; a reset mid-fill leaves the valid bit clear so this write is never observed.
  always_ff @(posedge CLK) begin
    if (fill_c) begin
      tag_q[mem_addr_q[IDX_W-1:0]]  <= mem_addr_q[BADR_W-1:IDX_W];
      data_q[mem_addr_q[IDX_W-1:0]] <= MEM_READDATA;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (!hit && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: random fetches against a line-level cache model and a
// word-addressed memory model with randomized read latency.
module tb_icache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    int          stall;
    int          mreads;
    logic [5:0]  maddr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  int          stall_c  = 0;
  int          mr_c     = 0;
  int          mem_n    = 0;
  bit          m_active = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] mem_words [256];
  bit          ref_valid [8];
  logic [2:0]  ref_tag   [8];
  logic [5:0]  ref_last_fill;
  int          exp_hits;
  int          exp_miss;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] block_of(input logic [5:0] a);
    int b;
    b = int'(a);
    return {mem_words[b*4+3], mem_words[b*4+2], mem_words[b*4+1], mem_words[b*4]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_last_fill = 6'd0;
    exp_hits      = 0;
    exp_miss      = 0;
  endfunction

  function automatic void check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_count", 32'(HIT_COUNT), 32'(exp_hits));
    check("miss_count", 32'(MISS_COUNT), 32'(exp_miss));
`endif
  endfunction

  task automatic finish_sim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Memory: after MEM_READ is seen, stay busy for mem_n cycles, then present the block.
  always @(negedge CLK) begin
    if (MEM_READ) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_cnt    = mem_n;
      end
      if (m_cnt == 0) begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = block_of(MEM_ADDRESS);
      end else begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_cnt--;
      end
    end else begin
      m_active     = 1'b0;
      MEM_BUSYWAIT = 1'b1;
    end
  end

  // Monitor: one scoreboard entry per cycle the DUT presents a valid instruction.
  always @(negedge CLK) begin
    if (!mon_en) begin
      stall_c = 0;
      mr_c    = 0;
    end else if (BUSYWAIT) begin
      stall_c++;
      if (MEM_READ) mr_c++;
      check("instr_zero_while_busy", INSTRUCTION, 32'h0);
    end else begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got instr 0x%0h, expected no output", INSTRUCTION);
      end else begin
        mon_e = sb_q.pop_front();
        check("instruction", INSTRUCTION, mon_e.instr);
        check("stall_cycles", 32'(stall_c), 32'(mon_e.stall));
        check("mem_read_cycles", 32'(mr_c), 32'(mon_e.mreads));
        check("mem_address", 32'(MEM_ADDRESS), 32'(mon_e.maddr));
        check("mem_read_low_on_hit", 32'(MEM_READ), 32'h0);
      end
      stall_c = 0;
      mr_c    = 0;
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BUSYWAIT && k < 100);
    if (BUSYWAIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: BUSYWAIT still 1 after %0d cycles, expected 0", k);
      finish_sim();
    end
  endtask

  task automatic wait_mem_read(input logic level);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (MEM_READ !== level && k < 50);
    if (MEM_READ !== level) begin
      n_checks++;
      n_fail++;
      $display("FAIL mem_read_timeout: MEM_READ=%0b, expected %0b", MEM_READ, level);
      finish_sim();
    end
  endtask

  // Issue one fetch with PC held until served; expected outcome comes from the line model.
  task automatic issue(input logic [31:0] pc, input int n, input bit rel_rst);
    exp_t       e;
    logic [2:0] t;
    logic [2:0] i;
    bit         h;
    @(posedge CLK);
    #1;
    check_stats();
    t = pc[9:7];
    i = pc[6:4];
    h = ref_valid[i] && (ref_tag[i] == t);
    e.instr = mem_words[pc[9:2]];
    if (h) begin
      e.stall  = 0;
      e.mreads = 0;
      e.maddr  = ref_last_fill;
    end else begin
      e.stall       = n + 3;
      e.mreads      = n + 1;
      e.maddr       = {t, i};
      ref_valid[i]  = 1'b1;
      ref_tag[i]    = t;
      ref_last_fill = {t, i};
      exp_miss++;
    end
    sb_q.push_back(e);
    mem_n  = n;
    PC     = pc;
    mon_en = 1'b1;
    if (rel_rst) RESET = 1'b0;
    wait_ready();
    exp_hits++;
  endtask

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    finish_sim();
  end

  initial begin
    logic [31:0] r;
    int          k;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom();
    RESET        = 1'b0;
    PC           = 32'h0;
    MEM_READDATA = '0;
    MEM_BUSYWAIT = 1'b1;
    model_reset();
    #1 RESET = 1'b1;
    #1;
    check("reset_mem_read", 32'(MEM_READ), 32'h0);
    check("reset_mem_address", 32'(MEM_ADDRESS), 32'h0);
    check("reset_busywait", 32'(BUSYWAIT), 32'h1);
    check("reset_instruction", INSTRUCTION, 32'h0);
    check_stats();

    // Cold fill of block 0 with 4 busy cycles, same-line hits, then a second miss.
    issue(32'h000, 4, 1'b1);
    issue(32'h004, 0, 1'b0);
    issue(32'h008, 0, 1'b0);
    issue(32'h00C, 0, 1'b0);
    issue(32'h010, 2, 1'b0);
    // Conflict on index 0 evicts tag 0, so returning to 0x000 misses again.
    issue(32'h080, 1, 1'b0);
    issue(32'h000, 0, 1'b0);

    // Reset in the cycle memory completes: fill must be dropped.
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    mem_n  = 2;
    PC     = 32'h040;
    wait_mem_read(1'b1);
    check("r34_mem_address", 32'(MEM_ADDRESS), 32'd4);
    #2;
    k = 0;
    while (MEM_BUSYWAIT && k < 20) begin
      @(negedge CLK);
      #2;
      k++;
    end
    check("r34_mem_busywait_low", 32'(MEM_BUSYWAIT), 32'h0);
    RESET = 1'b1;
    #1;
    check("r34_mem_read_async", 32'(MEM_READ), 32'h0);
    check("r34_mem_address_async", 32'(MEM_ADDRESS), 32'h0);
    check("r34_busywait_async", 32'(BUSYWAIT), 32'h1);
    check("r34_instruction_async", INSTRUCTION, 32'h0);
    model_reset();
    issue(32'h040, 3, 1'b1);

    // PC moves away during FETCH: the latched line is filled, then the new PC misses.
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    check_stats();
    mem_n = 3;
    PC    = 32'h010;
    wait_mem_read(1'b1);
    check("r35_first_fill_addr", 32'(MEM_ADDRESS), 32'd1);
    exp_miss++;
    @(posedge CLK);
    #1;
    PC = 32'h3F0;
    wait_mem_read(1'b0);
    wait_mem_read(1'b1);
    check("r35_second_fill_addr", 32'(MEM_ADDRESS), 32'd63);
    exp_miss++;
    ref_valid[1]  = 1'b1;
    ref_tag[1]    = 3'd0;
    ref_valid[7]  = 1'b1;
    ref_tag[7]    = 3'd7;
    ref_last_fill = 6'd63;
    wait_ready();
    check("r35_instr_3f0", INSTRUCTION, mem_words[8'hFC]);
    exp_hits++;
    @(posedge CLK);
    #1;
    PC = 32'h010;
    @(negedge CLK);
    check("r35_line1_hit", 32'(BUSYWAIT), 32'h0);
    check("r35_instr_010", INSTRUCTION, mem_words[8'h04]);
    check("r35_addr_held", 32'(MEM_ADDRESS), 32'd63);
    exp_hits++;

    // Random fetches; tags limited to 0..2 for a mix of hits, misses and evictions.
    for (int j = 0; j < 150; j++) begin
      r      = $urandom();
      r[9:7] = 3'($urandom_range(0, 2));
      issue(r, int'($urandom_range(0, 5)), 1'b0);
    end

    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    check_stats();
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    finish_sim();
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 lines x 16 bytes, direct-mapped, over a 1024-byte instruction space.
REQ-002 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port RESET  input  1  asynchronous, active-high reset.
REQ-004 Port PC  input  32  CPU fetch address; only PC[9:0] used, PC[1:0] ignored.
REQ-005 Port INSTRUCTION  output  32  fetched instruction word to CPU.
REQ-006 Port BUSYWAIT  output  1  high = CPU must stall, INSTRUCTION not valid.
REQ-007 Port MEM_READ  output  1  block-read request to instruction memory.
REQ-008 Port MEM_ADDRESS  output  6  block address {tag,index} of the line being filled.
REQ-009 Port MEM_READDATA  input  128  16-byte block returned by memory.
REQ-010 Port MEM_BUSYWAIT  input  1  high = memory read still in progress.

Function
REQ-011 Address split SHALL be tag=PC[9:7], index=PC[6:4], word=PC[3:2].
REQ-012 Storage SHALL be per line: valid (1b), tag (3b), data (128b); word w = data[32w+31:32w].
REQ-013 hit SHALL be combinational: valid[index] && tag[index]==PC[9:7].
REQ-014 FSM states SHALL be IDLE, FETCH, UPDATE.
REQ-015 IDLE: hit -> stay, INSTRUCTION = selected word, BUSYWAIT=0; miss -> FETCH at next edge.
REQ-016 On IDLE->FETCH the block SHALL latch {PC[9:7],PC[6:4]} into MEM_ADDRESS; later PC changes SHALL NOT affect the fill.
REQ-017 FETCH: MEM_READ=1; on an edge with MEM_BUSYWAIT=0, write MEM_READDATA, latched tag, valid=1 into the latched index and go to UPDATE.
REQ-018 UPDATE: MEM_READ=0 for one cycle, then IDLE unconditionally.
REQ-019 BUSYWAIT SHALL equal (state!=IDLE) || !hit, combinationally.
REQ-020 INSTRUCTION SHALL be 32'h0000_0000 whenever BUSYWAIT=1.
REQ-021 Miss latency, PC stable, memory busy N cycles in FETCH: BUSYWAIT high for N+3 cycles (IDLE-miss, N+1 FETCH, UPDATE), then a hit.
REQ-022 A miss evicting a valid line with a different tag SHALL overwrite it; no write-back.
REQ-023 MEM_ADDRESS SHALL hold its last latched value outside FETCH.

Reset
REQ-024 RESET high SHALL immediately clear all valid bits, force IDLE, MEM_READ=0, MEM_ADDRESS=0, without waiting for CLK.
REQ-025 RESET asserted during FETCH SHALL abort the fill; no line written, even if MEM_BUSYWAIT=0 the same cycle.
REQ-026 Tag and data arrays SHALL NOT require reset; outputs SHALL only depend on them through valid lines.
REQ-027 After RESET deasserts, the first fetch SHALL always miss.

Configuration
REQ-028 Macro ICACHE_STATS_EN defined: add outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], reset to 0.
REQ-029 With ICACHE_STATS_EN, HIT_COUNT SHALL increment on each edge in IDLE with hit; MISS_COUNT on each IDLE->FETCH; both saturate at 16'hFFFF.
REQ-030 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-031 Reset then PC=0, memory busy 4 cycles returning block 0 -> MEM_READ=1, MEM_ADDRESS=6'd0, BUSYWAIT high 7 cycles, then INSTRUCTION=word0, BUSYWAIT=0.
REQ-032 After fill of block 0, PC=4,8,12 -> each hit same cycle, BUSYWAIT=0, INSTRUCTION=words 1,2,3, MEM_READ stays 0.
REQ-033 PC=0x000 filled, then PC=0x080 (same index 0, tag 1) -> miss, MEM_ADDRESS=6'd8, line replaced; return to PC=0x000 -> miss again.
REQ-034 RESET pulsed mid-FETCH with MEM_BUSYWAIT falling same cycle -> MEM_READ low at once, state IDLE, next fetch of that PC misses.
REQ-035 PC changed to 0x3F0 during FETCH for PC=0x010 -> fill targets MEM_ADDRESS=6'd1 only; PC=0x3F0 then misses with MEM_ADDRESS=6'd63.
REQ-036 With ICACHE_STATS_EN, sequence 0,4,8,12,16 from cold, PC held each cycle until BUSYWAIT=0 -> MISS_COUNT=2, HIT_COUNT=5.
